// File: rtl/mem_sdp_asym_pkg.sv
// mem_pckg: shared types and helpers for the on-chip buffer family.
//   mem_cfg_t   - static configuration of one memory instance
//   mem_rd_lat  - read latency (rd_en sample edge to rd_valid) for a config
//   is_pow2     - elaboration-time power-of-two test
package mem_pckg;

  typedef struct packed {
    int unsigned wr_addr_wdt;   // narrow-word address width
    int unsigned data_in_wdt;   // narrow write word width
    int unsigned ratio;         // read/write width ratio
    int unsigned pipe_in_cnt;   // request-side register stages
    int unsigned pipe_out_cnt;  // stages after the RAM read register
  } mem_cfg_t;

  localparam mem_cfg_t MEM_CFG_DEFAULT = '{
    wr_addr_wdt:  10,
    data_in_wdt:  16,
    ratio:        4,
    pipe_in_cnt:  1,
    pipe_out_cnt: 2
  };

  // Cycles from the edge that samples rd_en to the cycle with rd_valid=1.
  function automatic int unsigned mem_rd_lat(mem_cfg_t cfg);
    return cfg.pipe_in_cnt + 1 + cfg.pipe_out_cnt;
  endfunction

  function automatic bit is_pow2(int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/mem_sdp_asym_pipe_reg.sv
// mem_pipe_reg: valid + data shift register of DEPTH stages.
//   clk, rst_n            - clock, asynchronous active-low reset
//   src_valid, src_data   - stage input
//   dst_valid, dst_data   - stage output (DEPTH=0: combinational pass-through)
// A stage only captures data when its incoming valid is set, so the output
// data holds the last valid word through idle cycles.
module mem_pipe_reg
  import mem_pckg::*;
#(
  parameter int WDT   = 8,
  parameter int DEPTH = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           src_valid,
  input  logic [WDT-1:0] src_data,
  output logic           dst_valid,
  output logic [WDT-1:0] dst_data
);

  if (DEPTH == 0) begin : g_pass
    assign dst_valid = src_valid;
    assign dst_data  = src_data;
  end else begin : g_pipe
    logic           valid_reg [DEPTH];
    logic [WDT-1:0] data_reg  [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic           stage_valid;
      logic [WDT-1:0] stage_data;

      if (gi == 0) begin : g_first
        assign stage_valid = src_valid;
        assign stage_data  = src_data;
      end else begin : g_next
        assign stage_valid = valid_reg[gi-1];
        assign stage_data  = data_reg[gi-1];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_reg[gi] <= 1'b0;
          data_reg[gi]  <= '0;
        end else begin
          valid_reg[gi] <= stage_valid;
          if (stage_valid) begin
            data_reg[gi] <= stage_data;
          end
        end
      end
    end

    assign dst_valid = valid_reg[DEPTH-1];
    assign dst_data  = data_reg[DEPTH-1];
  end

endmodule

// File: rtl/mem_sdp_asym.sv
// mem_sdp_asym: simple-dual-port buffer, narrow write port, wide read port.
//   clk, rst_n  - clock, asynchronous active-low reset
//   wr_en       - write request for one DATA_IN_WDT word
//   wr_addr     - narrow word address (row = upper bits, lane = low bits)
//   data_in     - write word
//   rd_en       - read request for one row of RATIO lanes
//   rd_addr     - wide row address
//   data_out    - row data, lane 0 in the least significant word
//   rd_valid    - data_out carries a read issued PIPE_IN_CNT+1+PIPE_OUT_CNT
//                 cycles earlier
// Each lane is its own narrow RAM so a write touches only the addressed lane.
// Read and write to the same row in the same RAM cycle return the old row.
module mem_sdp_asym
  import mem_pckg::*;
#(
  parameter int WR_ADDR_WDT  = 10,
  parameter int DATA_IN_WDT  = 16,
  parameter int RATIO        = 4,
  parameter int PIPE_IN_CNT  = 1,
  parameter int PIPE_OUT_CNT = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 wr_en,
  input  logic [WR_ADDR_WDT-1:0]               wr_addr,
  input  logic [DATA_IN_WDT-1:0]               data_in,
  input  logic                                 rd_en,
  input  logic [WR_ADDR_WDT-$clog2(RATIO)-1:0] rd_addr,
  output logic [DATA_IN_WDT*RATIO-1:0]         data_out,
  output logic                                 rd_valid
);

  localparam int LANE_W       = $clog2(RATIO);
  localparam int LANE_IDX_W   = (LANE_W > 0) ? LANE_W : 1;
  localparam int RD_ADDR_WDT  = WR_ADDR_WDT - LANE_W;
  localparam int DATA_OUT_WDT = DATA_IN_WDT * RATIO;
  localparam int ROWS         = 2 ** RD_ADDR_WDT;
  localparam int WR_REQ_WDT   = WR_ADDR_WDT + DATA_IN_WDT;

  if (!is_pow2(RATIO)) begin : g_bad_ratio
    $error("mem_sdp_asym: RATIO=%0d is not a power of two", RATIO);
  end
  if (WR_ADDR_WDT < LANE_W) begin : g_bad_addr
    $error("mem_sdp_asym: WR_ADDR_WDT=%0d narrower than log2(RATIO)=%0d",
           WR_ADDR_WDT, LANE_W);
  end

  // ---------------- request pipelines ----------------
  logic                   wr_req_valid;
  logic [WR_REQ_WDT-1:0]  wr_req_bus;
  logic [WR_ADDR_WDT-1:0] wr_req_addr;
  logic [DATA_IN_WDT-1:0] wr_req_data;
  logic                   rd_req_valid;
  logic [RD_ADDR_WDT-1:0] rd_req_row;

  mem_pipe_reg #(.WDT(WR_REQ_WDT), .DEPTH(PIPE_IN_CNT)) u_wr_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .src_valid (wr_en),
    .src_data  ({wr_addr, data_in}),
    .dst_valid (wr_req_valid),
    .dst_data  (wr_req_bus)
  );

  // Same depth as the write path so a read one cycle behind a write sees it.
  mem_pipe_reg #(.WDT(RD_ADDR_WDT), .DEPTH(PIPE_IN_CNT)) u_rd_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .src_valid (rd_en),
    .src_data  (rd_addr),
    .dst_valid (rd_req_valid),
    .dst_data  (rd_req_row)
  );

  assign {wr_req_addr, wr_req_data} = wr_req_bus;

  logic [RD_ADDR_WDT-1:0] wr_row;
  logic [LANE_IDX_W-1:0]  wr_lane;

  assign wr_row = wr_req_addr[WR_ADDR_WDT-1:LANE_W];

  if (LANE_W > 0) begin : g_lane_sel
    assign wr_lane = wr_req_addr[LANE_W-1:0];
  end else begin : g_single_lane
    assign wr_lane = '0;
  end

  // ---------------- lane RAMs ----------------
  logic [RATIO-1:0][DATA_IN_WDT-1:0] ram_rd_data;
  logic                              ram_rd_valid_reg;

  for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
    logic [DATA_IN_WDT-1:0] lane_mem [ROWS];
    logic [DATA_IN_WDT-1:0] lane_rd_reg;

    // Contents are deliberately not reset; a committed write survives rst_n.
    always_ff @(posedge clk) begin
      if (wr_req_valid && (int'(wr_lane) == gi)) begin
        lane_mem[wr_row] <= wr_req_data;
      end
    end

    // Registered read samples the array before this edge's write: read-first.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lane_rd_reg <= '0;
      end else if (rd_req_valid) begin
        lane_rd_reg <= lane_mem[rd_req_row];
      end
    end

    assign ram_rd_data[gi] = lane_rd_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_rd_valid_reg <= 1'b0;
    end else begin
      ram_rd_valid_reg <= rd_req_valid;
    end
  end

  // ---------------- output pipeline ----------------
  mem_pipe_reg #(.WDT(DATA_OUT_WDT), .DEPTH(PIPE_OUT_CNT)) u_out_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .src_valid (ram_rd_valid_reg),
    .src_data  (ram_rd_data),
    .dst_valid (rd_valid),
    .dst_data  (data_out)
  );

endmodule

// File: doc/mem_sdp_asym.md
# mem_sdp_asym

Simple-dual-port, width-asymmetric on-chip buffer with configurable input and output register pipelines and read-valid tracking. The write port is narrow (one `DATA_IN_WDT` word per write); the read port is wide (`RATIO` words per read). It sits between the CNN datapath writers and the wide-consumer read engines. It generalises the existing `mem_if` memory contract with:

- a width ratio,
- `PIPE_IN_CNT` / `PIPE_OUT_CNT` stages that are actually implemented,
- a `rd_valid` qualifier.

## Interface
Parameters:
- `WR_ADDR_WDT`, 10, narrow-word address width; depth = 2**`WR_ADDR_WDT` words.
- `DATA_IN_WDT`, 16, write word width.
- `RATIO`, 4, read/write width ratio; power of two, >= 1.
- `PIPE_IN_CNT`, 1, register stages on write and read request paths, >= 0.
- `PIPE_OUT_CNT`, 2, register stages after the RAM read register, >= 0.
- Derived, localparam: `RD_ADDR_WDT` = `WR_ADDR_WDT` - log2(`RATIO`); `DATA_OUT_WDT` = `DATA_IN_WDT`*`RATIO`.

Ports:
- `clk`  in  1  single clock, all logic rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  write request.
- `wr_addr`  in  `WR_ADDR_WDT`  narrow word address.
- `data_in`  in  `DATA_IN_WDT`  write data.
- `rd_en`  in  1  read request.
- `rd_addr`  in  `RD_ADDR_WDT`  wide row address.
- `data_out`  out  `DATA_OUT_WDT`  read data.
- `rd_valid`  out  1  `data_out` holds the result of a read issued `RD_LAT` cycles earlier.

## Operation
- Storage is 2**`RD_ADDR_WDT` rows of `RATIO` lanes.
- Write mapping:
  - row = `wr_addr` >> log2(`RATIO`); lane = `wr_addr`[log2(`RATIO`)-1:0].
  - Lane 0 occupies `data_out`[`DATA_IN_WDT`-1:0].
  - Only the addressed lane is modified (lane write-enable). Other lanes keep their contents.
- Request pipeline:
  - Requests enter through `PIPE_IN_CNT` stages, each carrying en/addr/data and a valid bit.
  - `PIPE_IN_CNT`=0 means requests hit the RAM in the same cycle they are presented.
- No back-pressure. A read or write may be issued every cycle, independently of each other.
- Read collision: a read and a write to the same row arriving at the RAM stage in the same cycle return the old row contents (read-first). The write commits normally.
- Read path:
  - The RAM read register is followed by `PIPE_OUT_CNT` stages.
  - A valid-bit shift register of equal length produces `rd_valid`.
- `data_out` holds its last value while `rd_valid`=0. Idle cycles do not clobber it.
- `RATIO`=1 degenerates to a symmetric memory with identical behaviour.
- Elaboration fails (`$error`) if `RATIO` is not a power of two or if `WR_ADDR_WDT` < log2(`RATIO`).

## Timing
- Read latency: `RD_LAT` = `PIPE_IN_CNT` + 1 + `PIPE_OUT_CNT` cycles, from the `rd_en` sample edge to `rd_valid`=1. Default `RD_LAT` is 4.
- Write commit: `PIPE_IN_CNT` + 1 edges after `wr_en` is sampled. A read issued in the cycle after a write (same latch depth) sees the new data.
- Throughput: one read and one write per cycle. `rd_valid` pulses track `rd_en` pulses exactly, delayed by `RD_LAT`.
- Reset values:
  - `rd_valid`=0 and `data_out`=0.
  - All pipeline valid bits = 0; pipeline data/addr registers = 0.
  - RAM contents are not reset.
- Reset mid-operation: in-flight reads are dropped (no `rd_valid`). Writes still in the input pipeline are dropped. A write already committed to the RAM persists.
- After `rst_n` deasserts, the first `rd_en` sampled produces `rd_valid` exactly `RD_LAT` cycles later.

## Structure
- `mem_pckg`:
  - Extend `mem_cfg_t` with `ratio` and `wr_addr_wdt`.
  - Add function `mem_rd_lat(cfg)` returning `pipe_in_cnt + 1 + pipe_out_cnt`, for benches and instantiating blocks.
- Sub-module `mem_pipe_reg`:
  - Parametrised (`WDT`, `DEPTH`) valid+data shift register with async active-low reset.
  - `DEPTH`=0 is a pass-through.
  - Used for the input request path and the output data/valid path.
- RAM array is inferred in the top module; no vendor primitive.

## Test plan
- Defaults. Write `wr_addr` 0..3 with data 0x1111, 0x2222, 0x3333, 0x4444; then read `rd_addr`=0 -> after 4 cycles `rd_valid`=1 and `data_out`=0x4444_3333_2222_1111.
- Write `wr_addr`=6 with data 0xBEEF into row 1, previously 0 -> read row 1 returns 0x0000_BEEF_0000_0000; other lanes unchanged.
- Back-to-back reads of rows 0,1,2 in 3 consecutive cycles -> `rd_valid` high for 3 consecutive cycles starting at cycle 4, with data in order.
- Collision: row 0 = 0x…1111. Same cycle: write `wr_addr`=0 with 0xAAAA and read row 0 -> old 0x…1111 returned; a read in the next cycle returns 0x…AAAA.
- Issue a read, then assert `rst_n`=0 for 1 cycle at cycle 2 -> no `rd_valid`; `data_out`=0. After reset, a read returns `rd_valid` exactly 4 cycles later.
- Sweep `PIPE_IN_CNT`/`PIPE_OUT_CNT` over {0,3}×{0,3} and `RATIO` over {1,8} -> measured latency equals `mem_rd_lat`, and the lane mapping holds.
